// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM DAC and the sample generators that feed it.
// FSM encodings, default window geometry and the code saturation rule.
package pwm_dac_pkg;

    typedef enum logic [1:0] {
        DAC_IDLE  = 2'd0,
        DAC_RUN   = 2'd1,
        DAC_DRAIN = 2'd2
    } dac_state_t;

    localparam int unsigned DEF_CYCLES_PER_WINDOW = 1024;
    localparam int unsigned DEF_CODE_WIDTH        = 10;

    // A code at or above the window length means "high for the whole window".
    function automatic int unsigned sat_code(input int unsigned c, input int unsigned w);
        return (c >= w) ? w : c;
    endfunction

endpackage

// File: rtl/pwm_dac_window_counter.sv
// Position counter inside one PWM window: counts 0..W-1 while advancing, parks at 0 otherwise.
// Also flags the last cycle of the window.
module window_counter
    import pwm_dac_pkg::*;
#(
    parameter int unsigned CYCLES_PER_WINDOW = DEF_CYCLES_PER_WINDOW,
    localparam int unsigned CW = $clog2(CYCLES_PER_WINDOW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES_PER_WINDOW - 1);

    // NOTE: rst_n is synchronous, so it is tested inside the clocked block and
    // all state updates use non-blocking assignments to avoid ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!advance) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Explicit wrap keeps non-power-of-two windows correct.
    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: turns one unsigned code per window into a 1-bit duty-cycled stream
// and requests the next code from upstream with a single-cycle next_sample.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int unsigned CYCLES_PER_WINDOW = DEF_CYCLES_PER_WINDOW,
    parameter int unsigned CODE_WIDTH        = DEF_CODE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  next_sample,
    output logic                  pwm,
    output logic                  active
);

    localparam int unsigned CW = $clog2(CYCLES_PER_WINDOW);
    // One extra bit so the duty register can hold the full window length.
    localparam int unsigned DW = CW + 1;

    dac_state_t    state;
    logic [CW-1:0] count;
    logic          last;
    logic [DW-1:0] duty_q;
    logic [DW-1:0] code_sat;
    logic          window_start;

    window_counter #(
        .CYCLES_PER_WINDOW(CYCLES_PER_WINDOW)
    ) u_window_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(state != DAC_IDLE),
        .count  (count),
        .last   (last)
    );

    assign code_sat     = DW'(sat_code(32'(code), CYCLES_PER_WINDOW));
    assign window_start = (state == DAC_RUN) && (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= DAC_IDLE;
            duty_q <= '0;
        end else begin
            // Code is captured only at window start; later changes wait for the next window.
            if (window_start) begin
                duty_q <= code_sat;
            end

            case (state)
                DAC_IDLE: begin
                    if (en) state <= DAC_RUN;
                end
                DAC_RUN: begin
                    if (!en) state <= last ? DAC_IDLE : DAC_DRAIN;
                end
                DAC_DRAIN: begin
                    if (en)        state <= DAC_RUN;
                    else if (last) state <= DAC_IDLE;
                end
                default: state <= DAC_IDLE;
            endcase
        end
    end

    // On the first cycle of a window duty_q is not loaded yet, so the live code decides.
    always_comb begin
        // NOTE: default first so every path assigns pwm and no latch is inferred.
        pwm = 1'b0;
        if (state != DAC_IDLE) begin
            if (count == '0) begin
                pwm = (code_sat != '0);
            end else begin
                pwm = ({1'b0, count} < duty_q);
            end
        end
    end

    assign next_sample = (state == DAC_RUN) && last;
    assign active      = (state != DAC_IDLE);

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: directed and random stimulus against a cycle model,
// plus a full-size instance driven by a square-wave style upstream loop.
module tb_pwm_dac;

    localparam int W   = 8;
    localparam int CWD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic [CWD-1:0] code  = '0;
    logic           next_sample, pwm, active;

    logic           en_big   = 1'b0;
    logic [9:0]     code_big = '0;
    logic           ns_big, pwm_big, act_big;

    pwm_dac #(.CYCLES_PER_WINDOW(W), .CODE_WIDTH(CWD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code),
        .next_sample(next_sample), .pwm(pwm), .active(active)
    );

    pwm_dac big (
        .clk(clk), .rst_n(rst_n), .en(en_big), .code(code_big),
        .next_sample(ns_big), .pwm(pwm_big), .active(act_big)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: window in progress, whether upstream is still requesting, position, duty.
    bit m_busy = 0;
    bit m_run  = 0;
    int m_pos  = 0;
    int m_duty = 0;
    int win_duty = 0;
    int acc = 0;

    function automatic int sat(input int c, input int w);
        return (c >= w) ? w : c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input int c);
        bit exp_pwm, exp_ns, last;
        @(negedge clk);
        rst_n = r;
        en    = e;
        code  = CWD'(c);
        #1;
        exp_pwm = m_busy && ((m_pos == 0) ? (sat(c, W) != 0) : (m_pos < m_duty));
        exp_ns  = m_busy && m_run && (m_pos == W - 1);
        check("pwm", {31'd0, pwm}, {31'd0, exp_pwm});
        check("next_sample", {31'd0, next_sample}, {31'd0, exp_ns});
        check("active", {31'd0, active}, {31'd0, m_busy});
        if (m_busy && m_run && m_pos == 0) begin
            acc = 0;
            win_duty = sat(c, W);
        end
        if (pwm === 1'b1) acc++;
        if (exp_ns) check("window_highs", acc, win_duty);

        @(posedge clk);
        if (!r) begin
            m_busy = 0; m_run = 0; m_pos = 0; m_duty = 0;
        end else if (!m_busy) begin
            if (e) begin m_busy = 1; m_run = 1; m_pos = 0; end
        end else begin
            last = (m_pos == W - 1);
            if (m_run && m_pos == 0) m_duty = sat(c, W);
            if (m_run) begin
                if (!e) begin
                    if (last) m_busy = 0;
                    else      m_run  = 0;
                end
            end else begin
                if (e)         m_run  = 1;
                else if (last) m_busy = 0;
            end
            m_pos = last ? 0 : m_pos + 1;
        end
    endtask

    task automatic window(input int c);
        for (int i = 0; i < W; i++) cycle(1, 1, c);
    endtask

    initial begin
        int cur, hi, nsn;

        // Reset held with en high: everything stays quiet.
        repeat (3) cycle(0, 1, 5);

        // Start and steady duty of 3.
        cycle(1, 1, 3);
        repeat (3) window(3);

        // Extremes and saturation.
        window(0);
        window(8);
        window(15);

        // Mid-window code change is ignored until the next window.
        for (int i = 0; i < W; i++) cycle(1, 1, (i < 3) ? 2 : 6);
        window(6);

        // Drain to idle, then drain interrupted by en returning.
        for (int i = 0; i < W; i++) cycle(1, i < 4, 5);
        cycle(1, 0, 5);
        cycle(1, 1, 5);
        for (int i = 0; i < W; i++) cycle(1, (i < 4) || (i >= 5), 5);
        window(4);

        // Reset in the middle of a window.
        repeat (3) cycle(1, 1, 7);
        cycle(0, 1, 7);
        repeat (2) cycle(1, 0, 0);

        // Random en / code / occasional reset.
        repeat (400) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                  int'($urandom_range(0, 15)));
        end
        repeat (10) cycle(1, 0, 0);

        // Full-size loop: upstream alternates 562/462 on each next_sample.
        cur = 562;
        hi  = 0;
        nsn = 0;
        @(negedge clk);
        code_big = 10'(cur);
        en_big   = 1'b1;
        for (int i = 0; i < 3 * 1024 + 8 && nsn < 3; i++) begin
            @(negedge clk);
            #1;
            if (act_big === 1'b1 && pwm_big === 1'b1) hi++;
            if (ns_big === 1'b1) begin
                check("loop_highs", hi, cur);
                nsn++;
                hi  = 0;
                cur = (cur == 562) ? 462 : 562;
                @(posedge clk);
                #1;
                code_big = 10'(cur);
            end
        end
        check("loop_windows", nsn, 3);
        en_big = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
